// File: rtl/simmem_delay_releaser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simmem_pkg
// Brief    : Shared constants, per-entry state type and helpers for the
//            simulated-memory response delay releaser.
// Revision : 1.0 - initial release
// ============================================================================
package simmem_pkg;

    // Response channel indices
    localparam int CH_RDATA = 0;
    localparam int CH_WRESP = 1;

    // Condition of one (channel, ID) tracking entry
    typedef enum logic [1:0] {
        ENTRY_EMPTY   = 2'd0,  // nothing outstanding
        ENTRY_DELAY   = 2'd1,  // head request still waiting out its delay
        ENTRY_RELEASE = 2'd2   // head response may be released
    } entry_state_e;

    // Classify an entry from its outstanding flag and expired-counter flag
    function automatic entry_state_e entry_state(input logic busy, input logic expired);
        entry_state_e s;
        s = ENTRY_EMPTY;
        if (busy) begin
            s = expired ? ENTRY_RELEASE : ENTRY_DELAY;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simmem_delay_releaser_if.sv
`default_nettype none
// ============================================================================
// Module   : simmem_delay_releaser_if
// Brief    : Request/response handshake and release-enable bundle between the
//            memory model environment (master) and the releaser (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface simmem_delay_releaser_if #(
    parameter int NumChannels = 2,
    parameter int IDWidth     = 4
);
    logic [NumChannels-1:0]                   req_valid_i;
    logic [NumChannels-1:0][IDWidth-1:0]      req_id_i;
    logic [NumChannels-1:0]                   req_ready_o;
    logic [NumChannels-1:0]                   rsp_valid_i;
    logic [NumChannels-1:0]                   rsp_ready_i;
    logic [NumChannels-1:0][IDWidth-1:0]      rsp_id_i;
    logic [NumChannels-1:0][2**IDWidth-1:0]   release_en_o;

    modport slave (
        input  req_valid_i, req_id_i, rsp_valid_i, rsp_ready_i, rsp_id_i,
        output req_ready_o, release_en_o
    );

    modport master (
        output req_valid_i, req_id_i, rsp_valid_i, rsp_ready_i, rsp_id_i,
        input  req_ready_o, release_en_o
    );
endinterface
`default_nettype wire

// File: rtl/simmem_delay_releaser_id_tracker.sv
`default_nettype none
// ============================================================================
// Module   : simmem_releaser_id_tracker
// Brief    : Outstanding count and head-of-line delay counter for a single
//            (channel, ID) pair. Responses for one ID are released strictly
//            in order, each one waiting its own full delay.
// Revision : 1.0 - initial release
// ============================================================================
module simmem_releaser_id_tracker
    import simmem_pkg::*;
#(
    parameter int DelayWidth     = 8,
    parameter int MaxOutstanding = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DelayWidth-1:0] cfg_delay_i,
    input  logic                  req_hs_i,   // request accepted for this ID
    input  logic                  rsp_hs_i,   // response handshake for this ID
    output logic                  full_o,
    output logic                  release_o,
    output logic                  rsp_err_o
);
    localparam int CntWidth = $clog2(MaxOutstanding + 1);

    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [DelayWidth-1:0] dly_q, dly_d;
    entry_state_e          w_state;
    logic                  w_rsp_ok;

    assign w_state   = entry_state(cnt_q != '0, dly_q == '0);
    assign release_o = (w_state == ENTRY_RELEASE);
    assign full_o    = (cnt_q == CntWidth'(MaxOutstanding));

    // A response is only legal while the head is released; otherwise it is
    // flagged and ignored.
    assign w_rsp_ok  = rsp_hs_i & release_o;
    assign rsp_err_o = rsp_hs_i & ~release_o;

    // Next count / head counter from the request and legal-response events
    always_comb begin
        cnt_d = cnt_q;
        dly_d = dly_q;
        if (req_hs_i && w_rsp_ok) begin
            // One leaves, one arrives: the new head starts a fresh delay
            dly_d = cfg_delay_i;
        end else if (req_hs_i) begin
            cnt_d = cnt_q + CntWidth'(1);
            if (cnt_q == '0) begin
                dly_d = cfg_delay_i;
            end else if (dly_q != '0) begin
                dly_d = dly_q - DelayWidth'(1);
            end
        end else if (w_rsp_ok) begin
            cnt_d = cnt_q - CntWidth'(1);
            if (cnt_q > CntWidth'(1)) begin
                dly_d = cfg_delay_i;
            end
        end else if (dly_q != '0) begin
            dly_d = dly_q - DelayWidth'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            dly_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dly_q <= dly_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/simmem_delay_releaser.sv
`default_nettype none
// ============================================================================
// Module   : simmem_delay_releaser
// Brief    : Tracks outstanding requests per (channel, ID) and enables each
//            response for release only after its programmed delay.
// Revision : 1.0 - initial release
// ============================================================================
module simmem_delay_releaser
    import simmem_pkg::*;
#(
    parameter int NumChannels    = 2,
    parameter int IDWidth        = 4,
    parameter int DelayWidth     = 8,
    parameter int MaxOutstanding = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumChannels-1:0][DelayWidth-1:0] cfg_delay_i,
    simmem_delay_releaser_if.slave                bus,
    output logic                                  error_o
);
    localparam int NumIds = 2**IDWidth;

    logic [NumChannels-1:0][NumIds-1:0] w_full;
    logic [NumChannels-1:0][NumIds-1:0] w_release;
    logic [NumChannels-1:0][NumIds-1:0] w_rsp_err;
    logic [NumChannels-1:0][NumIds-1:0] w_req_hs;
    logic [NumChannels-1:0][NumIds-1:0] w_rsp_hs;
    logic [NumChannels-1:0]             w_req_ready;
    logic                               error_q, error_d;

    generate
        for (genvar c = 0; c < NumChannels; c++) begin : g_chan
            // Back-pressure only the ID that has hit its outstanding limit
            assign w_req_ready[c] = ~w_full[c][bus.req_id_i[c]];

            for (genvar i = 0; i < NumIds; i++) begin : g_id
                assign w_req_hs[c][i] = bus.req_valid_i[c] & w_req_ready[c]
                                      & (bus.req_id_i[c] == IDWidth'(i));
                assign w_rsp_hs[c][i] = bus.rsp_valid_i[c] & bus.rsp_ready_i[c]
                                      & (bus.rsp_id_i[c] == IDWidth'(i));

                simmem_releaser_id_tracker #(
                    .DelayWidth     (DelayWidth),
                    .MaxOutstanding (MaxOutstanding)
                ) u_tracker (
                    .clk_i       (clk_i),
                    .rst_i       (rst_i),
                    .cfg_delay_i (cfg_delay_i[c]),
                    .req_hs_i    (w_req_hs[c][i]),
                    .rsp_hs_i    (w_rsp_hs[c][i]),
                    .full_o      (w_full[c][i]),
                    .release_o   (w_release[c][i]),
                    .rsp_err_o   (w_rsp_err[c][i])
                );
            end
        end
    endgenerate

    assign bus.req_ready_o  = w_req_ready;
    assign bus.release_en_o = w_release;
    assign error_o          = error_q;

    // Any premature response on any channel latches the protocol error
    always_comb begin
        error_d = error_q | (|w_rsp_err);
    end

    // Sticky error register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

endmodule
`default_nettype wire
